transfer_sequencer: RTL and testbench
=====================================

// Module: transfer_sequencer
// PURPOSE
// - Upstream control stage for general_registers: drives src_bus_selector, dest_bus_selector and data.
// - Accepts one 8-bit transfer instruction per valid/ready handshake and runs it as timed read/write bus phases.
// - Register SINK_REG is a reserved bit-bucket: whenever no transfer writes, dest points at it.
// PARAMETERS
// - SINK_REG      3'd7  selector parked on src/dest when idle; software must not keep live data there
// - READ_LATENCY  2     cycles src selector is held before src_in is valid (range 1..7)
// PORTS
// - clk               in   1  single clock, rising edge
// - reset             in   1  asynchronous, active-high reset
// - instr_valid       in   1  instr/imm present
// - instr             in   8  [7:6] op (00 MOV, 01 LDI, 10 NOP, 11 HALT), [5:3] src sel, [2:0] dest sel
// - imm               in   8  immediate for LDI; sampled with instr on handshake
// - instr_ready       out  1  1 only in S_IDLE; handshake = instr_valid & instr_ready at rising edge
// - src_in            in   8  general_registers src output
// - src_bus_selector  out  3  read selector to general_registers
// - dest_bus_selector out  3  write selector to general_registers (register latches every cycle)
// - data_out          out  8  value driven on general_registers data
// - busy              out  1  state != S_IDLE and != S_HALT
// - halted            out  1  state == S_HALT
// BEHAVIOUR
// - Reset (async): state S_IDLE; src/dest selectors = SINK_REG; data_out = 0; rd_cnt = 0; halted = 0; busy = 0.
// - All outputs registered except instr_ready/busy/halted, which decode the state register.
// - S_IDLE: src = dest = SINK_REG; data_out holds its last value. On handshake, decode op:
//   - MOV  -> S_READ, src = instr[5:3], rd_cnt = READ_LATENCY-1
//   - LDI  -> S_WRITE, data_out = imm
//   - NOP  -> stay in S_IDLE
//   - HALT -> S_HALT
// - S_READ: src held, dest = SINK_REG. rd_cnt decrements each cycle; at 0, capture src_in into data_out -> S_WRITE.
// - S_WRITE: exactly 1 cycle; dest = latched dest sel, data_out stable -> S_IDLE, dest back to SINK_REG.
// - S_HALT: instr_ready = 0, selectors parked on SINK_REG; only reset exits.
// - Latency (handshake edge = cycle 0):
//   - LDI: write cycle 1; next accept at cycle 2.
//   - MOV: read cycles 1..READ_LATENCY; write cycle READ_LATENCY+1; next accept at READ_LATENCY+2.
// - MOV src == dest is legal: rewrites the same value. dest == SINK_REG is legal: write is discarded by convention.
// - instr/imm are don't-care when no handshake occurs; instr_valid while busy is ignored (held by source).
// - Reset mid-operation: the transfer is aborted. No write to the target occurs after reset assertion.
// - Widths: 8-bit data pass-through only, no arithmetic. rd_cnt is 3 bits.
// CONFIGURATION
// - XFER_BYPASS_EN defined:
//   - Tracks last_dest/last_data/last_vld, updated in every S_WRITE; last_vld is cleared by reset.
//   - A MOV with last_vld & src == last_dest skips S_READ: data_out = last_data, -> S_WRITE at cycle 1.
//   - src_bus_selector is still driven to src for that one cycle.
//   - LDI/MOV writes to SINK_REG also update the tracker.
// - XFER_BYPASS_EN undefined: no tracker logic; every MOV takes the full READ_LATENCY read phase.
// TESTING
// - Reset: assert reset mid S_READ -> selectors 7/7, data_out 0, instr_ready 1 with no clock edge; R-target unchanged.
// - LDI: instr=8'b01_000_011, imm=8'hA5 -> cycle 1 dest=3, data_out=A5; cycle 2 dest=7, instr_ready=1.
// - MOV: R3=A5, instr=8'b00_011_001, READ_LATENCY=2 -> src=3 cycles 1-2; cycle 3 dest=1, data_out=A5; R1 reads A5.
// - Back-to-back: LDI R2=3C then MOV R2->R5 with instr_valid held high -> accepts at cycles 0 and 2; R5=3C at cycle 5.
// - HALT: instr=8'hC0 -> halted=1, instr_ready=0; further valid instrs ignored for 20 cycles; reset -> S_IDLE.
// - Bypass (XFER_BYPASS_EN): LDI R4=5A then MOV R4->R0 -> MOV write at cycle 1 after its accept, data_out=5A.

Source files
------------

// File: rtl/transfer_sequencer.sv
// Upstream control stage for general_registers: runs one MOV/LDI/NOP/HALT per handshake as timed read/write phases.
// Optional define XFER_BYPASS_EN forwards the last written value to a MOV that reads it, skipping the read phase.
module transfer_sequencer #(
  parameter logic [2:0]  SINK_REG     = 3'd7,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  input  logic [7:0] imm,
  output logic       instr_ready,
  input  logic [7:0] src_in,
  output logic [2:0] src_bus_selector,
  output logic [2:0] dest_bus_selector,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       halted
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_HALT} state_t;

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_LDI  = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b11;
  localparam logic [2:0] RD_INIT = 3'(READ_LATENCY - 1);

  state_t     state, state_nxt;
  logic [2:0] src_nxt, dest_nxt;
  logic [2:0] wr_dest, wr_dest_nxt;
  logic [2:0] rd_cnt, rd_cnt_nxt;
  logic [7:0] data_nxt;
  logic       accept;
  logic       bypass_hit;
  logic [7:0] bypass_data;

  assign accept      = instr_valid && (state == S_IDLE);
  assign instr_ready = (state == S_IDLE);
  assign busy        = (state == S_READ) || (state == S_WRITE);
  assign halted      = (state == S_HALT);

`ifdef XFER_BYPASS_EN
  logic [2:0] last_dest;
  logic [7:0] last_data;
  logic       last_vld;

  // Tracker mirrors whatever general_registers latches during each write cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_vld  <= 1'b0;
      last_dest <= SINK_REG;
      last_data <= 8'h00;
    end else if (state == S_WRITE) begin
      last_vld  <= 1'b1;
      last_dest <= dest_bus_selector;
      last_data <= data_out;
    end
  end

  assign bypass_hit  = last_vld && (instr[5:3] == last_dest);
  assign bypass_data = last_data;
`else
  assign bypass_hit  = 1'b0;
  assign bypass_data = 8'h00;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      src_bus_selector  <= SINK_REG;
      dest_bus_selector <= SINK_REG;
      wr_dest           <= SINK_REG;
      rd_cnt            <= 3'd0;
      data_out          <= 8'h00;
    end else begin
      state             <= state_nxt;
      src_bus_selector  <= src_nxt;
      dest_bus_selector <= dest_nxt;
      wr_dest           <= wr_dest_nxt;
      rd_cnt            <= rd_cnt_nxt;
      data_out          <= data_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    src_nxt     = src_bus_selector;
    dest_nxt    = dest_bus_selector;
    wr_dest_nxt = wr_dest;
    rd_cnt_nxt  = rd_cnt;
    data_nxt    = data_out;
    case (state)
      S_IDLE: begin
        src_nxt  = SINK_REG;
        dest_nxt = SINK_REG;
        if (accept) begin
          case (instr[7:6])
            OP_MOV: begin
              src_nxt     = instr[5:3];
              wr_dest_nxt = instr[2:0];
              if (bypass_hit) begin
                data_nxt  = bypass_data;
                dest_nxt  = instr[2:0];
                state_nxt = S_WRITE;
              end else begin
                rd_cnt_nxt = RD_INIT;
                state_nxt  = S_READ;
              end
            end
            OP_LDI: begin
              data_nxt    = imm;
              dest_nxt    = instr[2:0];
              wr_dest_nxt = instr[2:0];
              state_nxt   = S_WRITE;
            end
            OP_HALT: state_nxt = S_HALT;
            default: ;
          endcase
        end
      end
      S_READ: begin
        // src_in is only trustworthy once the selector has been held for READ_LATENCY cycles.
        dest_nxt = SINK_REG;
        if (rd_cnt == 3'd0) begin
          data_nxt  = src_in;
          src_nxt   = SINK_REG;
          dest_nxt  = wr_dest;
          state_nxt = S_WRITE;
        end else begin
          rd_cnt_nxt = rd_cnt - 3'd1;
        end
      end
      S_WRITE: begin
        src_nxt   = SINK_REG;
        dest_nxt  = SINK_REG;
        state_nxt = S_IDLE;
      end
      S_HALT: begin
        src_nxt  = SINK_REG;
        dest_nxt = SINK_REG;
      end
    endcase
  end

endmodule

// File: tb/tb_transfer_sequencer.sv
// Directed bench for transfer_sequencer with a behavioural general_registers (one-cycle registered read).
module tb_transfer_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       instr_valid = 1'b0;
  logic [7:0] instr = 8'h00;
  logic [7:0] imm = 8'h00;
  logic       instr_ready;
  logic [7:0] src_in;
  logic [2:0] src_bus_selector;
  logic [2:0] dest_bus_selector;
  logic [7:0] data_out;
  logic       busy;
  logic       halted;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  transfer_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .imm              (imm),
    .instr_ready      (instr_ready),
    .src_in           (src_in),
    .src_bus_selector (src_bus_selector),
    .dest_bus_selector(dest_bus_selector),
    .data_out         (data_out),
    .busy             (busy),
    .halted           (halted)
  );

  logic [7:0] regs [8];
  logic [7:0] src_q;
  always @(posedge clk) begin
    regs[dest_bus_selector] <= data_out;
    src_q <= regs[src_bus_selector];
  end
  assign src_in = src_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({src_bus_selector, dest_bus_selector, data_out, instr_ready, busy, halted} !== {3'd7, 3'd7, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got src=%0d dest=%0d data=%h rdy=%b busy=%b halt=%b exp 7/7/00/1/0/0",
               src_bus_selector, dest_bus_selector, data_out, instr_ready, busy, halted);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ldi();
    instr_valid = 1'b1; instr = 8'b01_000_011; imm = 8'hA5;
    tick();
    instr_valid = 1'b0;
    checks++;
    if ({dest_bus_selector, data_out, instr_ready, busy} !== {3'd3, 8'hA5, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL ldi_write got dest=%0d data=%h rdy=%b busy=%b exp 3/a5/0/1", dest_bus_selector, data_out, instr_ready, busy);
    end
    tick();
    checks++;
    if ({dest_bus_selector, instr_ready, busy} !== {3'd7, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL ldi_done got dest=%0d rdy=%b busy=%b exp 7/1/0", dest_bus_selector, instr_ready, busy);
    end
    checks++;
    if (regs[3] !== 8'hA5) begin
      failures++;
      $display("FAIL ldi_r3 got=%h exp=a5", regs[3]);
    end
  endtask

  task automatic test_mov();
    instr_valid = 1'b1; instr = 8'b01_000_110; imm = 8'h5C;
    tick();
    instr_valid = 1'b0;
    tick();
    instr_valid = 1'b1; instr = 8'b00_011_001; imm = 8'hFF;
    tick();
    instr_valid = 1'b0;
    checks++;
    if ({src_bus_selector, dest_bus_selector, busy, instr_ready} !== {3'd3, 3'd7, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL mov_read1 got src=%0d dest=%0d busy=%b rdy=%b exp 3/7/1/0", src_bus_selector, dest_bus_selector, busy, instr_ready);
    end
    tick();
    checks++;
    if ({src_bus_selector, dest_bus_selector, data_out} !== {3'd3, 3'd7, 8'h5C}) begin
      failures++;
      $display("FAIL mov_read2 got src=%0d dest=%0d data=%h exp 3/7/5c", src_bus_selector, dest_bus_selector, data_out);
    end
    tick();
    checks++;
    if ({dest_bus_selector, data_out, busy} !== {3'd1, 8'hA5, 1'b1}) begin
      failures++;
      $display("FAIL mov_write got dest=%0d data=%h busy=%b exp 1/a5/1", dest_bus_selector, data_out, busy);
    end
    tick();
    checks++;
    if ({dest_bus_selector, instr_ready, regs[1]} !== {3'd7, 1'b1, 8'hA5}) begin
      failures++;
      $display("FAIL mov_done got dest=%0d rdy=%b r1=%h exp 7/1/a5", dest_bus_selector, instr_ready, regs[1]);
    end
  endtask

  task automatic test_back_to_back();
    instr_valid = 1'b1; instr = 8'b01_000_010; imm = 8'h3C;
    tick();
    checks++;
    if ({dest_bus_selector, data_out, instr_ready} !== {3'd2, 8'h3C, 1'b0}) begin
      failures++;
      $display("FAIL b2b_ldi got dest=%0d data=%h rdy=%b exp 2/3c/0", dest_bus_selector, data_out, instr_ready);
    end
    instr = 8'b00_010_101; imm = 8'h00;
    tick();
    checks++;
    if ({instr_ready, busy} !== {1'b1, 1'b0}) begin
      failures++;
      $display("FAIL b2b_gap got rdy=%b busy=%b exp 1/0", instr_ready, busy);
    end
    tick();
    instr_valid = 1'b0;
`ifdef XFER_BYPASS_EN
    checks++;
    if ({src_bus_selector, dest_bus_selector, data_out} !== {3'd2, 3'd5, 8'h3C}) begin
      failures++;
      $display("FAIL b2b_bypass got src=%0d dest=%0d data=%h exp 2/5/3c", src_bus_selector, dest_bus_selector, data_out);
    end
    tick();
`else
    checks++;
    if ({src_bus_selector, dest_bus_selector, busy} !== {3'd2, 3'd7, 1'b1}) begin
      failures++;
      $display("FAIL b2b_accept got src=%0d dest=%0d busy=%b exp 2/7/1", src_bus_selector, dest_bus_selector, busy);
    end
    tick();
    tick();
    checks++;
    if ({dest_bus_selector, data_out} !== {3'd5, 8'h3C}) begin
      failures++;
      $display("FAIL b2b_write got dest=%0d data=%h exp 5/3c", dest_bus_selector, data_out);
    end
    tick();
`endif
    checks++;
    if ({regs[5], instr_ready} !== {8'h3C, 1'b1}) begin
      failures++;
      $display("FAIL b2b_r5 got r5=%h rdy=%b exp 3c/1", regs[5], instr_ready);
    end
  endtask

  task automatic test_nop();
    instr_valid = 1'b1; instr = 8'h80; imm = 8'h99;
    tick();
    tick();
    instr_valid = 1'b0;
    checks++;
    if ({instr_ready, busy, halted, dest_bus_selector, data_out} !== {1'b1, 1'b0, 1'b0, 3'd7, 8'h3C}) begin
      failures++;
      $display("FAIL nop got rdy=%b busy=%b halt=%b dest=%0d data=%h exp 1/0/0/7/3c",
               instr_ready, busy, halted, dest_bus_selector, data_out);
    end
  endtask

  task automatic test_reset_mid_read();
    instr_valid = 1'b1; instr = 8'b01_000_000; imm = 8'h11;
    tick();
    instr_valid = 1'b0;
    tick();
    instr_valid = 1'b1; instr = 8'b00_011_000;
    tick();
    instr_valid = 1'b0;
    tick();
    checks++;
    if ({src_bus_selector, busy} !== {3'd3, 1'b1}) begin
      failures++;
      $display("FAIL rst_pre got src=%0d busy=%b exp 3/1", src_bus_selector, busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({src_bus_selector, dest_bus_selector, data_out, instr_ready, busy, halted} !== {3'd7, 3'd7, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rst_async got src=%0d dest=%0d data=%h rdy=%b busy=%b halt=%b exp 7/7/00/1/0/0",
               src_bus_selector, dest_bus_selector, data_out, instr_ready, busy, halted);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (regs[0] !== 8'h11) begin
      failures++;
      $display("FAIL rst_target got r0=%h exp 11", regs[0]);
    end
  endtask

  task automatic test_halt();
    instr_valid = 1'b1; instr = 8'hC0;
    tick();
    checks++;
    if ({halted, instr_ready, busy} !== {1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL halt_enter got halt=%b rdy=%b busy=%b exp 1/0/0", halted, instr_ready, busy);
    end
    instr = 8'b01_000_001; imm = 8'hEE;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({halted, instr_ready, src_bus_selector, dest_bus_selector, data_out} !== {1'b1, 1'b0, 3'd7, 3'd7, 8'h00}) begin
        failures++;
        $display("FAIL halt_hold cyc=%0d got halt=%b rdy=%b src=%0d dest=%0d data=%h exp 1/0/7/7/00",
                 i, halted, instr_ready, src_bus_selector, dest_bus_selector, data_out);
      end
    end
    instr_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({halted, instr_ready} !== {1'b0, 1'b1}) begin
      failures++;
      $display("FAIL halt_exit got halt=%b rdy=%b exp 0/1", halted, instr_ready);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_bypass();
    instr_valid = 1'b1; instr = 8'b01_000_100; imm = 8'h5A;
    tick();
    instr_valid = 1'b0;
    tick();
    instr_valid = 1'b1; instr = 8'b00_100_000;
    tick();
    instr_valid = 1'b0;
`ifdef XFER_BYPASS_EN
    checks++;
    if ({src_bus_selector, dest_bus_selector, data_out, busy} !== {3'd4, 3'd0, 8'h5A, 1'b1}) begin
      failures++;
      $display("FAIL bypass_write got src=%0d dest=%0d data=%h busy=%b exp 4/0/5a/1",
               src_bus_selector, dest_bus_selector, data_out, busy);
    end
    tick();
`else
    checks++;
    if ({src_bus_selector, dest_bus_selector, busy} !== {3'd4, 3'd7, 1'b1}) begin
      failures++;
      $display("FAIL nobypass_read got src=%0d dest=%0d busy=%b exp 4/7/1", src_bus_selector, dest_bus_selector, busy);
    end
    tick();
    tick();
    tick();
`endif
    checks++;
    if ({regs[0], instr_ready} !== {8'h5A, 1'b1}) begin
      failures++;
      $display("FAIL bypass_r0 got r0=%h rdy=%b exp 5a/1", regs[0], instr_ready);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ldi();
    test_mov();
    test_back_to_back();
    test_nop();
    test_reset_mid_read();
    test_halt();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
